// File: rtl/core_pkg.sv
// Shared core definitions: data width, reset vector, major opcodes and the
// fetch buffer entry type used between fetch and decode.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; used both as the
// decode-side instruction buffer and as the in-flight PC queue.
module ifetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && full && !flush));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests, in-flight PC queue,
// instruction buffer to decode. Optional IFETCH_MISALIGN_TRAP_EN adds fetch_misalign.
module ifetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  logic            reset_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            halt;
  logic            req_hs, keep_rsp, pop_instr;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   fifo_count, pcq_count;
  fetch_entry_t    fifo_head, pcq_head, fifo_push_entry, pcq_push_entry;
  logic            unused_pcq_bits;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign halt           = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign halt = 1'b0;
`endif

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Credits cover both in-flight requests and buffered entries, so a response never finds the buffer full.
  assign imem_req_valid = !reset_q && !halt && (drop_cnt_q == '0) &&
                          (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign keep_rsp       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

  assign instr_valid    = (fifo_count != '0) && !halt;
  assign pop_instr      = instr_valid && instr_ready;
  assign instr          = instr_valid ? fifo_head.instr : '0;
  assign instr_pc       = instr_valid ? fifo_head.pc : '0;
  assign instr_pc_plus4 = instr_valid ? fifo_head.pc + XLEN'(4) : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    // Everything in flight after this edge belongs to the wrong path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign pcq_push_entry  = '{instr: 32'h0, pc: fetch_pc_q};
  assign fifo_push_entry = '{instr: imem_rsp_data, pc: pcq_head.pc};

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_hs),
    .push_data (pcq_push_entry),
    .pop       (keep_rsp),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (keep_rsp),
    .push_data (fifo_push_entry),
    .pop       (pop_instr),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign unused_pcq_bits = ^{pcq_head.instr, pcq_count};

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// memory latency / back-pressure / redirects against a sequential-PC model.
module tb_ifetch_unit;

  localparam int FIFO_DEPTH = 2;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus4;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  ifetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_log[$];
  logic [31:0] p4_log[$];

  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, n_dlv = 0;
  int          rdy_pct = 100, irdy_pct = 100, lat_min = 1, lat_max = 1;
  logic        do_redir = 1'b0;
  logic [31:0] redir_tgt = 32'h0;
  logic [31:0] exp_req_pc, exp_dlv_pc;
  logic        exp_mis = 1'b0, prev_pend = 1'b0, last_req_valid = 1'b0, last_mis = 1'b0;

  // Memory contents: any fixed scramble of the word address.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    do_redir = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_pc_plus4", instr_pc_plus4, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("rst_misalign", fetch_misalign, 0);
`endif
    reset = 1'b0;
    memq.delete();
    exp_req_pc = 32'h0;
    exp_dlv_pc = 32'h0;
    prev_pend  = 1'b0;
    exp_mis    = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then update the model.
  task automatic tick();
    logic rsp, hs;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? ref_word(memq[0].addr) : $urandom;
    instr_ready    = ($urandom_range(99) < irdy_pct);
    redirect_valid = do_redir;
    redirect_pc    = redir_tgt;
    #1;
    last_req_valid = imem_req_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
    last_mis = fetch_misalign;
    chk("misalign_flag", fetch_misalign, exp_mis);
`endif
    if (exp_mis) begin
      chk("mis_req_valid", imem_req_valid, 0);
      chk("mis_instr_valid", instr_valid, 0);
    end
    if (prev_pend) chk("req_hold", imem_req_valid, 1);
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
    if (instr_valid) begin
      chk("instr_pc", instr_pc, exp_dlv_pc);
      chk("instr_word", instr, ref_word(exp_dlv_pc));
      chk("instr_pc_plus4", instr_pc_plus4, exp_dlv_pc + 32'd4);
    end
    chk("outstanding_bound", memq.size() <= FIFO_DEPTH, 1);

    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      memq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      req_log.push_back(imem_req_addr);
      exp_req_pc += 32'd4;
    end
    if (rsp) void'(memq.pop_front());
    if (instr_valid && instr_ready && !redirect_valid) begin
      dlv_log.push_back(instr_pc);
      p4_log.push_back(instr_pc_plus4);
      exp_dlv_pc += 32'd4;
      n_dlv++;
    end
    prev_pend = imem_req_valid && !imem_req_ready && !redirect_valid;
    if (redirect_valid) begin
      exp_req_pc = {redir_tgt[31:2], 2'b00};
      exp_dlv_pc = {redir_tgt[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_TRAP_EN
      exp_mis = (redir_tgt[1:0] != 2'b00);
`endif
    end
    do_redir = 1'b0;
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    do_redir  = 1'b1;
    redir_tgt = tgt;
    tick();
  endtask

  initial begin
    int idx_d, idx_r, n_start;
    reset = 1'b1;

    // Reset release with 1-cycle memory and an always-ready decode stage.
    do_reset();
    repeat (12) tick();
    chk("p1_req_count", req_log.size() >= 3, 1);
    chk("p1_dlv_count", dlv_log.size() >= 3, 1);
    if (req_log.size() >= 3 && dlv_log.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk("p1_req_addr", req_log[i], 32'(i * 4));
        chk("p1_dlv_pc", dlv_log[i], 32'(i * 4));
      end

    // Decode stalls: requests must stop once the credits are used.
    irdy_pct = 0;
    repeat (6) tick();
    chk("p2_stall_req_valid", last_req_valid, 0);
    idx_d = dlv_log.size();
    irdy_pct = 100;
    repeat (10) tick();
    chk("p2_drain", dlv_log.size() >= idx_d + 2, 1);

    // Redirect with two responses still in flight.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 30 && memq.size() < 2; i++) tick();
    chk("p3_two_outstanding", memq.size(), 2);
    redirect_to(32'h0000_0100);
    idx_d = dlv_log.size();
    idx_r = req_log.size();
    repeat (30) tick();
    chk("p3_dlv_after", dlv_log.size() > idx_d, 1);
    chk("p3_req_after", req_log.size() > idx_r, 1);
    if (dlv_log.size() > idx_d) chk("p3_first_dlv_pc", dlv_log[idx_d], 32'h100);
    if (req_log.size() > idx_r) chk("p3_first_req_addr", req_log[idx_r], 32'h100);

    // Address wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    redirect_to(32'hFFFF_FFF8);
    idx_d = dlv_log.size();
    repeat (20) tick();
    chk("p5_dlv_count", dlv_log.size() >= idx_d + 3, 1);
    if (dlv_log.size() >= idx_d + 3) begin
      chk("p5_pc_f8", dlv_log[idx_d], 32'hFFFF_FFF8);
      chk("p5_pc_fc", dlv_log[idx_d + 1], 32'hFFFF_FFFC);
      chk("p5_pc_wrap", dlv_log[idx_d + 2], 32'h0);
      chk("p5_plus4_wrap", p4_log[idx_d + 1], 32'h0);
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    redirect_to(32'h0000_0102);
    tick();
    chk("p6_misalign_set", last_mis, 1);
    repeat (5) tick();
    chk("p6_no_req", last_req_valid, 0);
    redirect_to(32'h0000_0200);
    idx_d = dlv_log.size();
    repeat (15) tick();
    chk("p6_misalign_clr", last_mis, 0);
    chk("p6_dlv_after", dlv_log.size() > idx_d, 1);
    if (dlv_log.size() > idx_d) chk("p6_first_dlv_pc", dlv_log[idx_d], 32'h200);
`else
    // Without the trap, low target bits are simply ignored.
    redirect_to(32'h0000_0302);
    idx_d = dlv_log.size();
    repeat (15) tick();
    chk("p6_dlv_after", dlv_log.size() > idx_d, 1);
    if (dlv_log.size() > idx_d) chk("p6_first_dlv_pc", dlv_log[idx_d], 32'h300);
`endif

    // Random traffic: latency, ready, redirects (incl. coincident with handshakes).
    rdy_pct = 70; irdy_pct = 70; lat_min = 1; lat_max = 4;
    n_start = n_dlv;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(31) == 0) begin
        do_redir = 1'b1;
        case ($urandom_range(7))
          0:       redir_tgt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
          1:       redir_tgt = $urandom;
          default: redir_tgt = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      tick();
    end
    chk("rand_progress", (n_dlv - n_start) > 200, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
